// File: rtl/ag_pkg.sv
// Shared encodings, decoded-field bundle and effective-address helper for the AG stage.
// Declarations only: no state, no latency, no flow control.
package ag_pkg;

  localparam logic [1:0] MOD_IND   = 2'b00;
  localparam logic [1:0] MOD_D8    = 2'b01;
  localparam logic [1:0] MOD_D32   = 2'b10;
  localparam logic [1:0] MOD_REG   = 2'b11;
  localparam logic [2:0] RM_DISP32 = 3'b101;

  localparam int ST_DEPTH = 2;
  localparam int SEG_NUM  = 8;

  // Stores are tracked at word granularity.
  typedef logic [29:0] st_addr_t;

  typedef struct packed {
    logic        re;
    logic        we;
    logic        rmsel;
    logic        ro_needed;
    logic        rm_needed;
    logic [1:0]  alusel;
    logic [2:0]  jmp;
    logic [7:0]  modrm;
    logic [15:0] ptr;
    logic [31:0] dval;
    logic [31:0] sval;
    logic [31:0] flags;
    logic [31:0] flag_ld;
  } ag_fields_t;

  function automatic logic is_mem_mode(input logic [7:0] modrm);
    return modrm[7:6] != MOD_REG;
  endfunction

  function automatic logic [31:0] calc_ea(
    input logic [7:0]  modrm,
    input logic [31:0] seg,
    input logic [31:0] sval,
    input logic [31:0] disp
  );
    logic [31:0] ea;
    case (modrm[7:6])
      MOD_IND:         ea = (modrm[2:0] == RM_DISP32) ? seg + disp : seg + sval;
      MOD_D8, MOD_D32: ea = seg + sval + disp;
      default:         ea = '0;
    endcase
    return ea;
  endfunction

endpackage

// File: rtl/ag_store_tracker.sv
// Small in-order FIFO of outstanding store word addresses with an all-entry address compare.
// Hit/full are combinational from registered state; a pop on empty is dropped, a push on full relies on the caller stalling.
module ag_store_tracker
  import ag_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     i_push,
  input  logic     i_pop,
  input  st_addr_t i_cmp_addr,
  output logic     o_hit,
  output logic     o_full
);

  localparam int CNT_W = $clog2(ST_DEPTH + 1);
  localparam int IDX_W = $clog2(ST_DEPTH);

  st_addr_t         r_addr [ST_DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_slot;

  // Pop is applied before push, so a push alongside a pop may target the slot just vacated.
  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && (!o_full || w_pop);
  assign w_slot = r_cnt - CNT_W'(w_pop);
  assign o_full = (r_cnt == CNT_W'(ST_DEPTH));

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < ST_DEPTH; i++) begin
      if ((CNT_W'(i) < r_cnt) && (r_addr[i] == i_cmp_addr)) begin
        o_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
      for (int i = 0; i < ST_DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        for (int i = 0; i < ST_DEPTH - 1; i++) begin
          r_addr[i] <= r_addr[i+1];
        end
      end
      if (w_push) begin
        r_addr[w_slot[IDX_W-1:0]] <= i_cmp_addr;
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!clr) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/ag_stage.sv
// Address-generation pipeline register: segment-relative EA plus registered copies of decoded fields, one cycle.
// Holds on ld_ag=0; mem_dep tells decode to stall on a pending-store RAW hit or a full store tracker.
module ag_stage
  import ag_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        ld_ag,
  input  logic        ag_vin,
  input  logic        de_re,
  input  logic        de_we,
  input  logic        de_rmsel,
  input  logic [1:0]  de_alusel,
  input  logic [2:0]  de_jmp,
  input  logic [7:0]  de_modrm,
  input  logic [15:0] de_sreg,
  input  logic [15:0] de_ptr,
  input  logic [31:0] de_dval,
  input  logic [31:0] de_sval,
  input  logic [31:0] de_disp,
  input  logic [31:0] de_flags,
  input  logic [31:0] de_flag_ld,
  input  logic        ro_needed,
  input  logic        rm_needed,
  input  logic        seg_wr,
  input  logic [2:0]  seg_wr_idx,
  input  logic [31:0] seg_wr_base,
  input  logic        st_retire,
  output logic        mem_dep,
  output logic        ag_v,
  output logic [31:0] ag_ea,
  output logic        ag_re,
  output logic        ag_we,
  output logic        ag_rmsel,
  output logic        ag_ro_needed,
  output logic        ag_rm_needed,
  output logic [1:0]  ag_alusel,
  output logic [2:0]  ag_jmp,
  output logic [7:0]  ag_modrm,
  output logic [15:0] ag_ptr,
  output logic [31:0] ag_dval,
  output logic [31:0] ag_sval,
  output logic [31:0] ag_flags,
  output logic [31:0] ag_flag_ld
);

  logic [31:0] r_seg [SEG_NUM];
  logic        r_v;
  logic [31:0] r_ea;
  ag_fields_t  r_fld;

  logic [31:0] w_seg;
  logic        w_mem;
  logic [31:0] w_ea;
  logic        w_push;
  logic        w_hit;
  logic        w_full;
  ag_fields_t  w_fld;
  logic        w_sreg_unused;

  // Only the low three selector bits index the table.
  assign w_sreg_unused = ^de_sreg[15:3];

  // Reading the table before the write edge gives same-cycle readers the old base.
  assign w_seg  = r_seg[de_sreg[2:0]];
  assign w_mem  = is_mem_mode(de_modrm);
  assign w_ea   = calc_ea(de_modrm, w_seg, de_sval, de_disp);
  assign w_push = ld_ag && ag_vin && de_we && w_mem;

  // Independent of ld_ag so decode may fold mem_dep into ld_ag without a loop.
  assign mem_dep = ag_vin && w_mem && ((de_re && w_hit) || (de_we && w_full));

  ag_store_tracker u_store_tracker (
    .clk        (clk),
    .clr        (clr),
    .i_push     (w_push),
    .i_pop      (st_retire),
    .i_cmp_addr (w_ea[31:2]),
    .o_hit      (w_hit),
    .o_full     (w_full)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < SEG_NUM; i++) begin
        r_seg[i] <= '0;
      end
    end else if (seg_wr) begin
      r_seg[seg_wr_idx] <= seg_wr_base;
    end
  end

  always_comb begin
    w_fld           = '0;
    w_fld.re        = de_re;
    w_fld.we        = de_we;
    w_fld.rmsel     = de_rmsel;
    w_fld.ro_needed = ro_needed;
    w_fld.rm_needed = rm_needed;
    w_fld.alusel    = de_alusel;
    w_fld.jmp       = de_jmp;
    w_fld.modrm     = de_modrm;
    w_fld.ptr       = de_ptr;
    w_fld.dval      = de_dval;
    w_fld.sval      = de_sval;
    w_fld.flags     = de_flags;
    w_fld.flag_ld   = de_flag_ld;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_v   <= 1'b0;
      r_ea  <= '0;
      r_fld <= '0;
    end else if (ld_ag) begin
      r_v   <= ag_vin;
      r_ea  <= w_ea;
      r_fld <= w_fld;
    end
  end

  assign ag_v         = r_v;
  assign ag_ea        = r_ea;
  assign ag_re        = r_fld.re;
  assign ag_we        = r_fld.we;
  assign ag_rmsel     = r_fld.rmsel;
  assign ag_ro_needed = r_fld.ro_needed;
  assign ag_rm_needed = r_fld.rm_needed;
  assign ag_alusel    = r_fld.alusel;
  assign ag_jmp       = r_fld.jmp;
  assign ag_modrm     = r_fld.modrm;
  assign ag_ptr       = r_fld.ptr;
  assign ag_dval      = r_fld.dval;
  assign ag_sval      = r_fld.sval;
  assign ag_flags     = r_fld.flags;
  assign ag_flag_ld   = r_fld.flag_ld;

endmodule

// File: tb/tb_ag_stage.sv
// Scoreboard bench for ag_stage: directed scenarios plus random traffic against a queue-based reference model.
// A negedge monitor pops expected mem_dep / registered outputs and compares them with the DUT.
module tb_ag_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        ld_ag, ag_vin, de_re, de_we, de_rmsel, ro_needed, rm_needed, seg_wr, st_retire;
  logic [1:0]  de_alusel;
  logic [2:0]  de_jmp, seg_wr_idx;
  logic [7:0]  de_modrm;
  logic [15:0] de_sreg, de_ptr;
  logic [31:0] de_dval, de_sval, de_disp, de_flags, de_flag_ld, seg_wr_base;
  logic        mem_dep, ag_v, ag_re, ag_we, ag_rmsel, ag_ro_needed, ag_rm_needed;
  logic [31:0] ag_ea, ag_dval, ag_sval, ag_flags, ag_flag_ld;
  logic [1:0]  ag_alusel;
  logic [2:0]  ag_jmp;
  logic [7:0]  ag_modrm;
  logic [15:0] ag_ptr;

  always #5 clk = ~clk;

  ag_stage dut (
    .clk(clk), .clr(clr), .ld_ag(ld_ag), .ag_vin(ag_vin),
    .de_re(de_re), .de_we(de_we), .de_rmsel(de_rmsel), .de_alusel(de_alusel),
    .de_jmp(de_jmp), .de_modrm(de_modrm), .de_sreg(de_sreg), .de_ptr(de_ptr),
    .de_dval(de_dval), .de_sval(de_sval), .de_disp(de_disp), .de_flags(de_flags),
    .de_flag_ld(de_flag_ld), .ro_needed(ro_needed), .rm_needed(rm_needed),
    .seg_wr(seg_wr), .seg_wr_idx(seg_wr_idx), .seg_wr_base(seg_wr_base),
    .st_retire(st_retire), .mem_dep(mem_dep), .ag_v(ag_v), .ag_ea(ag_ea),
    .ag_re(ag_re), .ag_we(ag_we), .ag_rmsel(ag_rmsel), .ag_ro_needed(ag_ro_needed),
    .ag_rm_needed(ag_rm_needed), .ag_alusel(ag_alusel), .ag_jmp(ag_jmp),
    .ag_modrm(ag_modrm), .ag_ptr(ag_ptr), .ag_dval(ag_dval), .ag_sval(ag_sval),
    .ag_flags(ag_flags), .ag_flag_ld(ag_flag_ld)
  );

  typedef struct packed {
    logic        ld, vin, re, we, rmsel, ro, rm, retire, swr;
    logic [1:0]  alusel;
    logic [2:0]  jmp, swr_idx;
    logic [7:0]  modrm;
    logic [15:0] sreg, ptr;
    logic [31:0] dval, sval, disp, flags, flag_ld, swr_base;
  } stim_t;

  int n_checks = 0;
  int n_errors = 0;
  logic dep_seen;

  // Reference model state
  logic [31:0]  m_seg [8];
  logic [29:0]  m_trk [$];
  logic         m_v;
  logic [31:0]  m_ea;
  logic [161:0] m_fld;

  logic         q_dep [$];
  logic [194:0] q_out [$];

  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [161:0] pack_fields(input stim_t s);
    return {s.re, s.we, s.rmsel, s.ro, s.rm, s.alusel, s.jmp, s.modrm, s.ptr,
            s.dval, s.sval, s.flags, s.flag_ld};
  endfunction

  function automatic logic [161:0] dut_fields();
    return {ag_re, ag_we, ag_rmsel, ag_ro_needed, ag_rm_needed, ag_alusel, ag_jmp,
            ag_modrm, ag_ptr, ag_dval, ag_sval, ag_flags, ag_flag_ld};
  endfunction

  function automatic logic [31:0] model_ea(input stim_t s);
    logic [31:0] base;
    base = m_seg[s.sreg[2:0]];
    if (s.modrm[7:6] == 2'd3) return 32'd0;
    if (s.modrm[7:6] == 2'd0) return (s.modrm[2:0] == 3'd5) ? base + s.disp : base + s.sval;
    return base + s.sval + s.disp;
  endfunction

  function automatic logic model_dep(input stim_t s);
    logic [31:0] ea;
    logic hit;
    ea = model_ea(s);
    hit = 1'b0;
    foreach (m_trk[i]) if (m_trk[i] == ea[31:2]) hit = 1'b1;
    return s.vin && (s.modrm[7:6] != 2'd3) &&
           ((s.re && hit) || (s.we && (m_trk.size() == 2)));
  endfunction

  task automatic model_clock(input stim_t s);
    logic [31:0] ea;
    ea = model_ea(s);
    if (s.retire && m_trk.size() > 0) void'(m_trk.pop_front());
    if (s.ld && s.vin && s.we && (s.modrm[7:6] != 2'd3)) m_trk.push_back(ea[31:2]);
    if (s.swr) m_seg[s.swr_idx] = s.swr_base;
    if (s.ld) begin
      m_v = s.vin;
      m_ea = ea;
      m_fld = pack_fields(s);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_seg[i] = 32'd0;
    m_trk.delete();
    m_v = 1'b0;
    m_ea = 32'd0;
    m_fld = '0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t op(input logic [7:0] modrm, input logic [15:0] sreg,
                               input logic [31:0] sval, input logic [31:0] disp,
                               input logic re, input logic we, input logic ld, input logic vin);
    stim_t s;
    s = '0;
    s.modrm = modrm; s.sreg = sreg; s.sval = sval; s.disp = disp;
    s.re = re; s.we = we; s.ld = ld; s.vin = vin;
    s.ptr = 16'hBEEF; s.dval = 32'h0D0D0D0D; s.flags = 32'h5; s.jmp = 3'd2;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.ld       = ($urandom_range(0, 3) != 0);
    s.vin      = ($urandom_range(0, 7) != 0);
    s.re       = 1'($urandom_range(0, 1));
    s.we       = ($urandom_range(0, 4) < 2);
    s.rmsel    = 1'($urandom_range(0, 1));
    s.ro       = 1'($urandom_range(0, 1));
    s.rm       = 1'($urandom_range(0, 1));
    s.retire   = ($urandom_range(0, 4) == 0);
    s.swr      = ($urandom_range(0, 7) == 0);
    s.swr_idx  = 3'($urandom_range(0, 7));
    s.swr_base = 32'($urandom_range(0, 3)) << 6;
    s.alusel   = 2'($urandom);
    s.jmp      = 3'($urandom);
    s.modrm    = 8'($urandom);
    s.sreg     = 16'($urandom);
    s.ptr      = 16'($urandom);
    s.dval     = $urandom;
    s.sval     = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
    s.disp     = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
    s.flags    = $urandom;
    s.flag_ld  = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ld_ag = s.ld; ag_vin = s.vin; de_re = s.re; de_we = s.we; de_rmsel = s.rmsel;
    ro_needed = s.ro; rm_needed = s.rm; st_retire = s.retire; seg_wr = s.swr;
    de_alusel = s.alusel; de_jmp = s.jmp; seg_wr_idx = s.swr_idx; de_modrm = s.modrm;
    de_sreg = s.sreg; de_ptr = s.ptr; de_dval = s.dval; de_sval = s.sval;
    de_disp = s.disp; de_flags = s.flags; de_flag_ld = s.flag_ld; seg_wr_base = s.swr_base;
  endtask

  // Called just after a posedge; returns just after the next one.
  task automatic step(input stim_t s);
    drive(s);
    q_dep.push_back(model_dep(s));
    #1 dep_seen = mem_dep;
    @(posedge clk);
    model_clock(s);
    q_out.push_back({m_v, m_ea, m_fld});
    #1;
  endtask

  task automatic reset_release();
    q_dep.delete();
    q_out.delete();
    model_reset();
    drive(idle());
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    q_out.push_back({m_v, m_ea, m_fld});
  endtask

  always @(negedge clk) begin
    logic         e_dep;
    logic [194:0] e_out;
    if (q_dep.size() > 0) begin
      e_dep = q_dep.pop_front();
      chk("sb_mem_dep", {161'd0, mem_dep}, {161'd0, e_dep});
    end
    if (q_out.size() > 0) begin
      e_out = q_out.pop_front();
      chk("sb_ag_v", {161'd0, ag_v}, {161'd0, e_out[194]});
      chk("sb_ag_ea", {130'd0, ag_ea}, {130'd0, e_out[193:162]});
      chk("sb_ag_fields", dut_fields(), e_out[161:0]);
    end
  end

  initial begin
    stim_t s;
    clr = 1'b0;
    drive(op(8'h05, 16'd0, 32'd0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1));
    #12;
    chk("rst_ag_v", {161'd0, ag_v}, 162'd0);
    chk("rst_ag_ea", {130'd0, ag_ea}, 162'd0);
    chk("rst_fields", dut_fields(), 162'd0);
    chk("rst_mem_dep", {161'd0, mem_dep}, 162'd0);
    reset_release();

    s = idle(); s.swr = 1'b1; s.swr_idx = 3'd1; s.swr_base = 32'h1000;
    step(s);

    step(op(8'hC1, 16'd1, 32'h77, 32'h9, 1'b1, 1'b0, 1'b1, 1'b1));
    chk("reg_mode_v", {161'd0, ag_v}, 162'd1);
    chk("reg_mode_ea", {130'd0, ag_ea}, 162'd0);
    chk("reg_mode_modrm", {154'd0, ag_modrm}, 162'hC1);

    step(op(8'h81, 16'd1, 32'h20, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1));
    chk("disp_ea", {130'd0, ag_ea}, 162'h1024);
    step(op(8'h81, 16'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 1'b1, 1'b1));
    chk("wrap_ea", {130'd0, ag_ea}, 162'h1);

    step(op(8'h45, 16'd1, 32'h10, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) begin
      s = rnd(); s.ld = 1'b0; s.retire = 1'b0;
      step(s);
      chk("stall_ea", {130'd0, ag_ea}, 162'h1018);
      chk("stall_v", {161'd0, ag_v}, 162'd1);
      chk("stall_modrm", {154'd0, ag_modrm}, 162'h45);
    end
    step(op(8'h45, 16'd1, 32'h10, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("bubble_v", {161'd0, ag_v}, 162'd0);

    step(op(8'h05, 16'd0, 32'd0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1));
    step(op(8'h05, 16'd0, 32'd0, 32'h42, 1'b1, 1'b0, 1'b0, 1'b1));
    chk("hazard_hit", {161'd0, dep_seen}, 162'd1);
    step(op(8'h05, 16'd0, 32'd0, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1));
    chk("hazard_miss", {161'd0, dep_seen}, 162'd0);
    step(op(8'h05, 16'd0, 32'd0, 32'h80, 1'b0, 1'b1, 1'b1, 1'b1));
    step(op(8'h05, 16'd0, 32'd0, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b1));
    chk("full_block", {161'd0, dep_seen}, 162'd1);
    s = op(8'h05, 16'd0, 32'd0, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b1); s.retire = 1'b1;
    step(s);
    chk("full_until_edge", {161'd0, dep_seen}, 162'd1);
    step(op(8'h05, 16'd0, 32'd0, 32'hC0, 1'b0, 1'b1, 1'b1, 1'b1));
    chk("after_retire", {161'd0, dep_seen}, 162'd0);

    s = idle(); s.retire = 1'b1;
    step(s);
    s = op(8'h05, 16'd0, 32'd0, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1); s.retire = 1'b1;
    step(s);
    step(op(8'h05, 16'd0, 32'd0, 32'h140, 1'b0, 1'b1, 1'b0, 1'b1));
    chk("simul_not_full", {161'd0, dep_seen}, 162'd0);
    step(op(8'h05, 16'd0, 32'd0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1));
    chk("simul_pushed", {161'd0, dep_seen}, 162'd1);
    step(op(8'h05, 16'd0, 32'd0, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b1));
    chk("simul_popped", {161'd0, dep_seen}, 162'd0);

    s = idle(); s.retire = 1'b1;
    step(s);
    s = op(8'h05, 16'd0, 32'd0, 32'h200, 1'b0, 1'b1, 1'b1, 1'b1); s.retire = 1'b1;
    step(s);
    step(op(8'h05, 16'd0, 32'd0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1));
    chk("empty_simul_push", {161'd0, dep_seen}, 162'd1);
    step(op(8'h05, 16'd0, 32'd0, 32'h240, 1'b0, 1'b1, 1'b1, 1'b1));

    drive(op(8'h05, 16'd0, 32'd0, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1));
    #1;
    chk("pre_clr_dep", {161'd0, mem_dep}, 162'd1);
    chk("pre_clr_v", {161'd0, ag_v}, 162'd1);
    clr = 1'b0;
    #1;
    chk("clr_ag_v", {161'd0, ag_v}, 162'd0);
    chk("clr_ag_ea", {130'd0, ag_ea}, 162'd0);
    chk("clr_mem_dep", {161'd0, mem_dep}, 162'd0);
    reset_release();

    step(op(8'h81, 16'd1, 32'h20, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1));
    chk("fresh_ea", {130'd0, ag_ea}, 162'h24);
    step(op(8'h05, 16'd0, 32'd0, 32'h240, 1'b1, 1'b1, 1'b0, 1'b1));
    chk("fresh_no_dep", {161'd0, dep_seen}, 162'd0);

    for (int n = 0; n < 400; n++) begin
      s = rnd();
      if (model_dep(s)) s.ld = 1'b0;
      step(s);
    end
    step(idle());
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
